// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer: default geometry, entry layout, wrap-aware occupancy.
// Pure declarations; no latency or backpressure of its own.
package rob_pkg;

    localparam int ROB_DEPTH_DEF  = 32;
    localparam int ROB_DATA_W_DEF = 32;
    localparam int ROB_RD_W_DEF   = 5;
    localparam int ROB_PC_W_DEF   = 32;
    // Widest pointer needed for the largest supported depth (64 entries + wrap bit).
    localparam int ROB_PTR_W_MAX  = 7;

    typedef struct packed {
        logic                      valid;
        logic                      done;
        logic                      mispredict;
        logic [ROB_RD_W_DEF-1:0]   rd;
        logic [ROB_PC_W_DEF-1:0]   pc;
        logic [ROB_DATA_W_DEF-1:0] data;
        logic [ROB_PC_W_DEF-1:0]   target;
    } rob_entry_t;

    // Low bits of the difference are exact for any narrower pointer zero-extended into this width.
    function automatic logic [ROB_PTR_W_MAX-1:0] rob_count(
        input logic [ROB_PTR_W_MAX-1:0] tail,
        input logic [ROB_PTR_W_MAX-1:0] head
    );
        return tail - head;
    endfunction

endpackage

// File: rtl/rob_tracker.sv
// In-order reorder buffer: program-order allocate, CDB completion, in-order retire with mispredict flush.
// Latency: CDB completion visible at retire one cycle later; flush_out one cycle after the retiring mispredict. Backpressure: alloc_ready drops when full or flushing; retire holds on !retire_ready.
module rob_tracker
    import rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH_DEF,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int PC_W   = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              alloc_valid,
    input  logic [RD_W-1:0]   alloc_rd,
    input  logic [PC_W-1:0]   alloc_pc,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [IDX_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispredict,
    input  logic [PC_W-1:0]   cdb_target,
    output logic              retire_valid,
    input  logic              retire_ready,
    output logic [RD_W-1:0]   retire_rd,
    output logic [DATA_W-1:0] retire_data,
    output logic [IDX_W-1:0]  retire_tag,
    input  logic              flush_in,
    output logic              flush_out,
    output logic [PC_W-1:0]   flush_target,
    output logic              o_full,
    output logic              o_empty,
    output logic [IDX_W:0]    o_count
);

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              mispredict;
        logic [RD_W-1:0]   rd;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   target;
    } entry_t;

    entry_t            r_ent [DEPTH];
    logic [IDX_W:0]    r_head;
    logic [IDX_W:0]    r_tail;
    logic              r_flush_out;
    logic [PC_W-1:0]   r_flush_target;

    logic [IDX_W-1:0]  w_head_idx;
    logic [IDX_W-1:0]  w_tail_idx;
    logic [IDX_W:0]    w_count;
    logic              w_alloc;
    logic              w_retire;
    logic              w_mispred_flush;
    logic              w_flush;
    logic              w_cdb_hit;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_count    = (IDX_W+1)'(rob_count(ROB_PTR_W_MAX'(r_tail), ROB_PTR_W_MAX'(r_head)));

    assign o_count      = w_count;
    assign o_full       = (w_count == (IDX_W+1)'(DEPTH));
    assign o_empty      = (r_head == r_tail);
    assign alloc_ready  = !o_full && !flush_in;
    assign alloc_tag    = w_tail_idx;

    assign retire_valid = r_ent[w_head_idx].valid && r_ent[w_head_idx].done && !o_empty;
    assign retire_rd    = r_ent[w_head_idx].rd;
    assign retire_data  = r_ent[w_head_idx].data;
    assign retire_tag   = w_head_idx;

    assign flush_out    = r_flush_out;
    assign flush_target = r_flush_target;

    assign w_alloc         = alloc_valid && alloc_ready;
    assign w_retire        = retire_valid && retire_ready;
    assign w_mispred_flush = w_retire && r_ent[w_head_idx].mispredict;
    assign w_flush         = w_mispred_flush || flush_in;
    assign w_cdb_hit       = cdb_valid && r_ent[cdb_tag].valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_flush_out    <= 1'b0;
            r_flush_target <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i].valid <= 1'b0;
                r_ent[i].done  <= 1'b0;
            end
        end else begin
            r_flush_out <= w_mispred_flush;
            if (w_mispred_flush) begin
                r_flush_target <= r_ent[w_head_idx].target;
            end
            // Any flush squashes the whole window, including this cycle's alloc/CDB/retire.
            if (w_flush) begin
                r_head <= '0;
                r_tail <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_ent[i].valid <= 1'b0;
                    r_ent[i].done  <= 1'b0;
                end
            end else begin
                if (w_cdb_hit) begin
                    r_ent[cdb_tag].done       <= 1'b1;
                    r_ent[cdb_tag].data       <= cdb_data;
                    r_ent[cdb_tag].mispredict <= cdb_mispredict;
                    r_ent[cdb_tag].target     <= cdb_target;
                end
                if (w_retire) begin
                    r_ent[w_head_idx].valid <= 1'b0;
                    r_head                  <= r_head + 1'b1;
                end
                if (w_alloc) begin
                    r_ent[w_tail_idx].valid      <= 1'b1;
                    r_ent[w_tail_idx].done       <= 1'b0;
                    r_ent[w_tail_idx].mispredict <= 1'b0;
                    r_ent[w_tail_idx].rd         <= alloc_rd;
                    r_ent[w_tail_idx].pc         <= alloc_pc;
                    r_tail                       <= r_tail + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_tracker.sv
// Bench for rob_tracker: directed scenarios plus a randomized run against a queue-based ROB model.
module tb_rob_tracker;
    import rob_pkg::*;

    localparam int DEPTH = ROB_DEPTH_DEF;
    localparam int IDX_W = $clog2(DEPTH);

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              alloc_valid;
    logic [4:0]        alloc_rd;
    logic [31:0]       alloc_pc;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_tag;
    logic              cdb_valid;
    logic [IDX_W-1:0]  cdb_tag;
    logic [31:0]       cdb_data;
    logic              cdb_mispredict;
    logic [31:0]       cdb_target;
    logic              retire_valid;
    logic              retire_ready;
    logic [4:0]        retire_rd;
    logic [31:0]       retire_data;
    logic [IDX_W-1:0]  retire_tag;
    logic              flush_in;
    logic              flush_out;
    logic [31:0]       flush_target;
    logic              o_full;
    logic              o_empty;
    logic [IDX_W:0]    o_count;

    int vectors     = 0;
    int miscompares = 0;

    // Model: in-flight entries in program order; q[k] carries ROB index (m_head + k) mod DEPTH.
    rob_entry_t  q[$];
    int          m_head;
    logic        m_flush_out;
    logic [31:0] m_flush_tgt;

    rob_tracker dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .retire_valid(retire_valid), .retire_ready(retire_ready),
        .retire_rd(retire_rd), .retire_data(retire_data), .retire_tag(retire_tag),
        .flush_in(flush_in), .flush_out(flush_out), .flush_target(flush_target),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic int m_tail();
        return (m_head + q.size()) % DEPTH;
    endfunction

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_rd = '0; alloc_pc = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_mispredict = 1'b0; cdb_target = '0;
        retire_ready = 1'b0; flush_in = 1'b0;
    endtask

    task automatic model_clear();
        q.delete();
        m_head = 0;
        m_flush_out = 1'b0;
        m_flush_tgt = '0;
    endtask

    // Apply the ROB rules to the inputs currently driven, producing the post-edge state.
    task automatic model_step();
        bit         ret;
        bit         mis;
        bit         alloc_ok;
        int         k;
        rob_entry_t e;
        ret      = (q.size() > 0) && q[0].done && retire_ready;
        mis      = ret && q[0].mispredict;
        alloc_ok = alloc_valid && (q.size() < DEPTH) && !flush_in;
        m_flush_out = mis;
        if (mis) m_flush_tgt = q[0].target;
        if (mis || flush_in) begin
            q.delete();
            m_head = 0;
            return;
        end
        if (cdb_valid) begin
            k = (int'(cdb_tag) - m_head + DEPTH) % DEPTH;
            if (k < q.size()) begin
                q[k].done       = 1'b1;
                q[k].data       = cdb_data;
                q[k].mispredict = cdb_mispredict;
                q[k].target     = cdb_target;
            end
        end
        if (ret) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (alloc_ok) begin
            e = '0;
            e.valid = 1'b1;
            e.rd    = alloc_rd;
            e.pc    = alloc_pc;
            q.push_back(e);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        #1;
        vectors++; if (alloc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
        vectors++; if (alloc_tag !== '0) begin miscompares++; $display("FAIL reset_alloc_tag: got %0d expected 0", alloc_tag); end
        vectors++; if (retire_valid !== 1'b0) begin miscompares++; $display("FAIL reset_retire_valid: got %b expected 0", retire_valid); end
        vectors++; if (flush_out !== 1'b0 || flush_target !== 32'h0) begin miscompares++; $display("FAIL reset_flush: got %b/%h expected 0/0", flush_out, flush_target); end
        vectors++; if (o_empty !== 1'b1 || o_full !== 1'b0 || o_count !== '0) begin miscompares++; $display("FAIL reset_occupancy: got empty %b full %b count %0d expected 1 0 0", o_empty, o_full, o_count); end
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_alloc_basic();
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1); alloc_pc = 32'h1000 + 32'(4 * i);
            #1;
            vectors++; if (alloc_tag !== IDX_W'(i) || alloc_ready !== 1'b1) begin miscompares++; $display("FAIL alloc_tag_%0d: got tag %0d ready %b expected tag %0d ready 1", i, alloc_tag, alloc_ready, i); end
            tick();
        end
        alloc_valid = 1'b0;
        #1;
        vectors++; if (o_count !== 6'd3) begin miscompares++; $display("FAIL alloc_count: got %0d expected 3", o_count); end
        vectors++; if (retire_valid !== 1'b0) begin miscompares++; $display("FAIL alloc_no_retire: got %b expected 0", retire_valid); end
    endtask

    task automatic test_complete_retire();
        retire_ready = 1'b1;
        cdb_valid = 1'b1; cdb_tag = IDX_W'(1); cdb_data = 32'hAA;
        #1; tick();
        cdb_tag = IDX_W'(0); cdb_data = 32'h55;
        #1;
        vectors++; if (retire_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_head_blocked: got %b expected 0", retire_valid); end
        tick();
        cdb_valid = 1'b0;
        #1;
        vectors++; if (retire_valid !== 1'b1 || retire_tag !== IDX_W'(0) || retire_data !== 32'h55 || retire_rd !== 5'd1) begin miscompares++; $display("FAIL retire_first: got v%b tag %0d data %h rd %0d expected v1 tag 0 data 55 rd 1", retire_valid, retire_tag, retire_data, retire_rd); end
        tick(); #1;
        vectors++; if (retire_valid !== 1'b1 || retire_tag !== IDX_W'(1) || retire_data !== 32'hAA || retire_rd !== 5'd2) begin miscompares++; $display("FAIL retire_second: got v%b tag %0d data %h rd %0d expected v1 tag 1 data aa rd 2", retire_valid, retire_tag, retire_data, retire_rd); end
        tick(); #1;
        vectors++; if (retire_valid !== 1'b0 || o_count !== 6'd1) begin miscompares++; $display("FAIL retire_hold_tag2: got v%b count %0d expected v0 count 1", retire_valid, o_count); end
        retire_ready = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i); alloc_pc = 32'(i);
            #1;
            vectors++; if (alloc_tag !== IDX_W'(i)) begin miscompares++; $display("FAIL fill_tag_%0d: got %0d expected %0d", i, alloc_tag, i); end
            tick();
        end
        #1;
        vectors++; if (o_full !== 1'b1 || alloc_ready !== 1'b0 || o_count !== 6'd32 || alloc_tag !== '0) begin miscompares++; $display("FAIL full_state: got full %b ready %b count %0d tag %0d expected 1 0 32 0", o_full, alloc_ready, o_count, alloc_tag); end
        cdb_valid = 1'b1; cdb_tag = '0; cdb_data = 32'h1234;
        tick();
        cdb_valid = 1'b0; retire_ready = 1'b1;
        #1;
        vectors++; if (retire_valid !== 1'b1 || alloc_ready !== 1'b0) begin miscompares++; $display("FAIL full_no_bypass: got retire %b ready %b expected 1 0", retire_valid, alloc_ready); end
        tick();
        retire_ready = 1'b0;
        #1;
        vectors++; if (o_full !== 1'b0 || o_count !== 6'd31 || alloc_ready !== 1'b1 || alloc_tag !== '0) begin miscompares++; $display("FAIL after_retire: got full %b count %0d ready %b tag %0d expected 0 31 1 0", o_full, o_count, alloc_ready, alloc_tag); end
        tick();
        alloc_valid = 1'b0;
        #1;
        vectors++; if (o_full !== 1'b1 || o_count !== 6'd32 || alloc_tag !== IDX_W'(1)) begin miscompares++; $display("FAIL wrap_refill: got full %b count %0d tag %0d expected 1 32 1", o_full, o_count, alloc_tag); end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 4); alloc_pc = 32'h200 + 32'(i);
            tick();
        end
        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = '0; cdb_data = 32'h77; cdb_mispredict = 1'b1; cdb_target = 32'h100;
        tick();
        cdb_valid = 1'b0; cdb_mispredict = 1'b0; retire_ready = 1'b1;
        #1;
        vectors++; if (retire_valid !== 1'b1 || flush_out !== 1'b0) begin miscompares++; $display("FAIL mis_pre: got retire %b flush %b expected 1 0", retire_valid, flush_out); end
        tick();
        retire_ready = 1'b0;
        #1;
        vectors++; if (flush_out !== 1'b1 || flush_target !== 32'h100) begin miscompares++; $display("FAIL mis_flush: got %b/%h expected 1/100", flush_out, flush_target); end
        vectors++; if (o_empty !== 1'b1 || alloc_tag !== '0 || o_count !== '0) begin miscompares++; $display("FAIL mis_empty: got empty %b tag %0d count %0d expected 1 0 0", o_empty, alloc_tag, o_count); end
        tick(); #1;
        vectors++; if (flush_out !== 1'b0) begin miscompares++; $display("FAIL mis_pulse: got %b expected 0", flush_out); end
    endtask

    task automatic test_flush_in();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1); tick();
        end
        flush_in = 1'b1; cdb_valid = 1'b1; cdb_tag = '0; cdb_data = 32'hDEAD;
        #1;
        vectors++; if (alloc_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b expected 0", alloc_ready); end
        tick();
        flush_in = 1'b0; cdb_valid = 1'b0;
        #1;
        vectors++; if (o_empty !== 1'b1 || flush_out !== 1'b0 || alloc_tag !== '0) begin miscompares++; $display("FAIL flush_in_empty: got empty %b flush %b tag %0d expected 1 0 0", o_empty, flush_out, alloc_tag); end
        tick();
        alloc_valid = 1'b0;
        #1;
        vectors++; if (retire_valid !== 1'b0 || o_count !== 6'd1) begin miscompares++; $display("FAIL flush_in_cdb_dropped: got retire %b count %0d expected 0 1", retire_valid, o_count); end
        cdb_valid = 1'b1; cdb_tag = '0; cdb_mispredict = 1'b1; cdb_target = 32'h200;
        tick();
        cdb_valid = 1'b0; cdb_mispredict = 1'b0; flush_in = 1'b1; retire_ready = 1'b1;
        tick();
        flush_in = 1'b0; retire_ready = 1'b0;
        #1;
        vectors++; if (flush_out !== 1'b1 || flush_target !== 32'h200 || o_empty !== 1'b1) begin miscompares++; $display("FAIL flush_in_plus_mis: got %b/%h empty %b expected 1/200 empty 1", flush_out, flush_target, o_empty); end
    endtask

    task automatic test_random();
        logic             e_rdy;
        logic             e_rv;
        logic [IDX_W-1:0] e_tag;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            alloc_valid    = ($urandom_range(0, 3) != 0);
            alloc_rd       = 5'($urandom);
            alloc_pc       = $urandom;
            cdb_valid      = ($urandom_range(0, 9) < 6);
            if (q.size() > 0 && $urandom_range(0, 7) != 0)
                cdb_tag = IDX_W'((m_head + int'($urandom_range(0, q.size() - 1))) % DEPTH);
            else
                cdb_tag = IDX_W'($urandom_range(0, DEPTH - 1));
            cdb_data       = $urandom;
            cdb_mispredict = ($urandom_range(0, 31) == 0);
            cdb_target     = $urandom;
            retire_ready   = ($urandom_range(0, 9) < 6);
            flush_in       = ($urandom_range(0, 99) == 0);
            #1;
            e_rdy = (q.size() < DEPTH) && !flush_in;
            e_rv  = (q.size() > 0) && q[0].done;
            e_tag = IDX_W'(m_tail());
            vectors++; if (alloc_ready !== e_rdy || alloc_tag !== e_tag) begin miscompares++; $display("FAIL rnd_alloc cyc %0d: got ready %b tag %0d expected %b %0d", c, alloc_ready, alloc_tag, e_rdy, e_tag); end
            vectors++; if (o_count !== (IDX_W+1)'(q.size()) || o_full !== (q.size() == DEPTH) || o_empty !== (q.size() == 0)) begin miscompares++; $display("FAIL rnd_occ cyc %0d: got count %0d full %b empty %b expected %0d", c, o_count, o_full, o_empty, q.size()); end
            vectors++; if (retire_valid !== e_rv) begin miscompares++; $display("FAIL rnd_retire_valid cyc %0d: got %b expected %b", c, retire_valid, e_rv); end
            if (e_rv) begin
                vectors++; if (retire_tag !== IDX_W'(m_head) || retire_rd !== q[0].rd || retire_data !== q[0].data) begin miscompares++; $display("FAIL rnd_retire_dat cyc %0d: got tag %0d rd %0d data %h expected %0d %0d %h", c, retire_tag, retire_rd, retire_data, m_head, q[0].rd, q[0].data); end
            end
            vectors++; if (flush_out !== m_flush_out || (m_flush_out && flush_target !== m_flush_tgt)) begin miscompares++; $display("FAIL rnd_flush cyc %0d: got %b/%h expected %b/%h", c, flush_out, flush_target, m_flush_out, m_flush_tgt); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 8); tick();
        end
        alloc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cdb_valid = 1'b1; cdb_tag = IDX_W'(i); cdb_data = 32'(i); tick();
        end
        cdb_valid = 1'b0; retire_ready = 1'b1;
        #1;
        vectors++; if (retire_valid !== 1'b1 || o_count !== 6'd4) begin miscompares++; $display("FAIL arst_pre: got retire %b count %0d expected 1 4", retire_valid, o_count); end
        #2 i_rst_n = 1'b0;
        #1;
        vectors++; if (retire_valid !== 1'b0 || o_count !== '0 || o_empty !== 1'b1 || o_full !== 1'b0) begin miscompares++; $display("FAIL arst_immediate: got retire %b count %0d empty %b full %b expected 0 0 1 0", retire_valid, o_count, o_empty, o_full); end
        vectors++; if (alloc_ready !== 1'b1 || alloc_tag !== '0 || flush_out !== 1'b0) begin miscompares++; $display("FAIL arst_alloc: got ready %b tag %0d flush %b expected 1 0 0", alloc_ready, alloc_tag, flush_out); end
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_clear();
        retire_ready = 1'b0;
        #1;
        vectors++; if (o_count !== '0 || retire_valid !== 1'b0) begin miscompares++; $display("FAIL arst_after: got count %0d retire %b expected 0 0", o_count, retire_valid); end
    endtask

    initial begin
        idle_inputs();
        i_rst_n = 1'b1;
        model_clear();
        @(negedge i_clk);
        test_reset();
        test_alloc_basic();
        test_complete_retire();
        test_full();
        test_mispredict();
        test_flush_in();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rob_tracker.md
Name: rob_tracker

Overview:
- Parametrised reorder buffer that succeeds the tag-only ROB FIFO.
- Allocates entries in program order at dispatch and returns each entry's ROB index as its tag.
- Marks entries complete from the CDB (data plus mispredict info) and retires in order from the head with a valid/ready handshake.
- On a head mispredict, generates a pipeline flush with redirect target. Sits between dispatch/rename, the CDB and the register-file commit port.

Parameters:
- DEPTH, 32, number of entries; power of two, 4..64.
- DATA_W, 32, result width.
- RD_W, 5, destination register index width.
- PC_W, 32, PC / redirect target width.
- IDX_W, $clog2(DEPTH), entry index width (derived, not overridable).

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- alloc_valid  in  1  dispatch requests an entry.
- alloc_rd  in  RD_W  destination register of the instruction (0 = none).
- alloc_pc  in  PC_W  PC of the instruction.
- alloc_ready  out  1  entry available (= !o_full && !flush_in).
- alloc_tag  out  IDX_W  index the next allocation receives (tail index).
- cdb_valid  in  1  completion broadcast.
- cdb_tag  in  IDX_W  ROB index being completed.
- cdb_data  in  DATA_W  result.
- cdb_mispredict  in  1  completing branch was mispredicted.
- cdb_target  in  PC_W  correct redirect PC.
- retire_valid  out  1  head entry complete and presentable.
- retire_ready  in  1  commit stage accepts.
- retire_rd  out  RD_W  head rd.
- retire_data  out  DATA_W  head result.
- retire_tag  out  IDX_W  head index.
- flush_in  in  1  external flush (e.g. exception).
- flush_out  out  1  one-cycle pulse: head mispredict retired.
- flush_target  out  PC_W  redirect PC, valid when flush_out = 1.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_count  out  IDX_W+1  occupied entries.

Behaviour:
- Pointers head and tail are IDX_W+1 bits wide; the MSB is the wrap bit.
  - count = tail - head, modulo 2^(IDX_W+1).
  - o_full when count == DEPTH; o_empty when head == tail.
- Per-entry state: valid, done, mispredict, rd, pc, data, target.
- Reset:
  - head = tail = 0; all valid and done bits cleared.
  - Outputs after reset: alloc_ready = 1, alloc_tag = 0, retire_valid = 0, flush_out = 0, flush_target = 0, o_empty = 1, o_full = 0, o_count = 0.
  - Data arrays are not reset.
  - Reset asserted mid-operation discards all entries immediately (asynchronous).
- Allocate:
  - On the edge where alloc_valid && alloc_ready, write entry[tail]: valid = 1, done = 0, mispredict = 0, plus rd and pc; then tail++.
  - alloc_tag equals tail[IDX_W-1:0] in that cycle.
  - alloc_ready depends only on the current full state. There is no same-cycle bypass from retire, so a full ROB refuses allocation even if it retires that cycle.
- Complete:
  - On cdb_valid, if entry[cdb_tag].valid, set done = 1 and write data, mispredict and target.
  - A CDB to an invalid entry is ignored.
  - A completion is visible at retire the next cycle (registered; no CDB-to-retire bypass).
  - A completion is accepted as early as the cycle after allocation.
- Retire:
  - retire_valid = entry[head].valid && entry[head].done && !o_empty. All retire_* outputs are combinational from entry[head].
  - On retire_valid && retire_ready: clear entry[head].valid and increment head.
  - Retire and allocate in the same cycle are both honoured; count is unchanged.
- Mispredict:
  - If a retiring head entry has mispredict = 1, flush_out = 1 and flush_target = that entry's target in the next cycle (registered, one-cycle pulse).
  - At that same edge, all entries are invalidated and head = tail = 0.
  - Allocation, CDB and retire in the flushing cycle are discarded.
- flush_in:
  - Takes effect at the next edge with the same pointer/valid clear as a mispredict.
  - Forces alloc_ready = 0 during the cycle it is asserted.
  - Does not assert flush_out.
  - flush_in and a mispredict retire in the same cycle: flush_out still pulses with the entry's target.
- Wrap-around: pointers increment mod 2^(IDX_W+1); entry index = pointer[IDX_W-1:0].

Decomposition:
- Shared package rob_pkg:
  - rob_entry_t struct: valid, done, mispredict, rd, pc, data, target.
  - ROB_DEPTH_DEF constant.
  - Helper function for the wrap-aware count.
- Sub-modules: none required. The entry array plus the two pointer counters fit in one module of roughly 200 lines.

Test Plan:
- Reset, then allocate 3 entries (rd = 1, 2, 3) -> alloc_tag 0, 1, 2 on successive cycles; o_count = 3; retire_valid = 0.
- CDB tag 1 (data 0xAA), then tag 0 (data 0x55), retire_ready = 1 throughout -> tag 0 retires with 0x55, then tag 1 with 0xAA; tag 2 is held (retire_valid = 0).
- Allocate 32 entries -> o_full = 1, alloc_ready = 0. Complete and retire one entry while allocating -> full is held; allocation accepted only the next cycle. Continue until tail wraps past 31 -> alloc_tag = 0, count correct.
- Entry 0 completes with mispredict = 1, target 0x100, with 5 entries live -> after retire, flush_out pulses 1 cycle with 0x100; o_empty = 1; next alloc_tag = 0.
- flush_in asserted with alloc_valid = 1 and cdb_valid = 1 the same cycle -> alloc_ready = 0, CDB dropped, ROB empty next cycle, flush_out = 0.
- i_rst_n pulled low mid-cycle with 4 live entries -> outputs immediately at reset values, no retire.
